dcnt16_timer: RTL and testbench

DCNT16_TIMER -- requirements
Module: dcnt16_timer

---
 rtl/dcnt16_timer.sv | 82 ++++++++
 tb/tb_dcnt16_timer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dcnt16_timer.sv
// Loadable down-counter timer with one-shot or auto-reload operation.
// bout flags terminal count combinationally; done is a one-cycle completion pulse.
module dcnt16_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             auto_rl,
    output logic [WIDTH-1:0] dout,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] count, count_nx;
    logic [WIDTH-1:0] reload, reload_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            reload <= reload_nx;
        end
    end

    // Terminal count is seen from the current state, so a same-cycle stop
    // does not hide it while en is high.
    assign bout = (state == RUN) && en && (count == '0);

    always_comb begin
        state_nx  = state;
        count_nx  = count;
        reload_nx = reload;
        if (load) begin
            count_nx  = din;
            reload_nx = din;
            state_nx  = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop)
                        state_nx = RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_nx = IDLE;
                    end else if (en) begin
                        if (count != '0)
                            count_nx = count - WIDTH'(1);
                        else if (auto_rl)
                            count_nx = reload;
                        else
                            state_nx = DONE;
                    end
                end
                DONE: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    assign dout = count;
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_dcnt16_timer.sv
// Bench for dcnt16_timer: directed scenarios with literal expectations plus
// randomized stimulus, all checked every cycle against a behavioural model.
module tb_dcnt16_timer;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load = 1'b0, start = 1'b0, stop = 1'b0, en = 1'b0, auto_rl = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] dout;
    logic             bout, busy, done;

    int checks = 0;
    int fails  = 0;

    dcnt16_timer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .load(load), .din(din), .start(start), .stop(stop),
        .en(en), .auto_rl(auto_rl), .dout(dout), .bout(bout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: phase 0 = idle, 1 = running, 2 = finished pulse.
    int               m_phase = 0;
    logic [WIDTH-1:0] m_cnt = '0;
    logic [WIDTH-1:0] m_rl  = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_cnt = '0; m_rl = '0;
        end else if (load) begin
            m_cnt = din; m_rl = din; m_phase = 0;
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (start && !stop) m_phase = 1;
        end else if (stop) begin
            m_phase = 0;
        end else if (en) begin
            if (m_cnt > 0)      m_cnt = m_cnt - 1;
            else if (auto_rl)   m_cnt = m_rl;
            else                m_phase = 2;
        end
    end

    always @(negedge clk) begin
        chk("dout_model", 32'(dout), 32'(m_cnt));
        chk("bout_model", 32'(bout), 32'(m_phase == 1 && en && m_cnt == 0));
        chk("busy_model", 32'(busy), 32'(m_phase == 1));
        chk("done_model", 32'(done), 32'(m_phase == 2));
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load = 1'b1; din = v; step(); load = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1; step(); start = 1'b0;
    endtask

    int n;

    initial begin
        // Reset state
        #2;
        chk("rst_dout", 32'(dout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bout", 32'(bout), 0);
        #10 rst = 1'b1;
        step();
        chk("post_rst_idle", 32'(busy), 0);

        // One-shot from 5
        en = 1'b1; auto_rl = 1'b0;
        do_load(16'd5);
        do_start();
        for (int k = 5; k >= 0; k--) begin
            chk("os_dout", 32'(dout), 32'(k));
            chk("os_busy", 32'(busy), 1);
            chk("os_bout", 32'(bout), 32'(k == 0));
            step();
        end
        chk("os_done", 32'(done), 1);
        chk("os_done_busy", 32'(busy), 0);
        step();
        chk("os_done_clr", 32'(done), 0);
        chk("os_idle", 32'(busy), 0);

        // Auto-reload with period 4
        auto_rl = 1'b1;
        do_load(16'd3);
        do_start();
        for (int i = 0; i < 10; i++) begin
            chk("ar_dout", 32'(dout), 32'(3 - (i % 4)));
            chk("ar_bout", 32'(bout), 32'(i % 4 == 3));
            chk("ar_done", 32'(done), 0);
            step();
        end
        auto_rl = 1'b0;

        // Pause / gating
        do_load(16'd10);
        do_start();
        step(); step(); step();
        chk("pz_at7", 32'(dout), 7);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pz_hold", 32'(dout), 7);
        end
        stop = 1'b1; step(); stop = 1'b0;
        chk("pz_stop_busy", 32'(busy), 0);
        chk("pz_stop_dout", 32'(dout), 7);
        en = 1'b1;
        do_start();
        chk("pz_resume_dout", 32'(dout), 7);
        step();
        chk("pz_resume6", 32'(dout), 6);
        step();
        chk("pz_resume5", 32'(dout), 5);

        // Priority: load beats start/stop while running
        do_load(16'd12);
        do_start();
        step(); step(); step();
        chk("pr_at9", 32'(dout), 9);
        load = 1'b1; start = 1'b1; stop = 1'b1; din = 16'h0010;
        step();
        load = 1'b0; start = 1'b0; stop = 1'b0;
        chk("pr_dout", 32'(dout), 32'h10);
        chk("pr_busy", 32'(busy), 0);

        // Zero count after reset
        rst = 1'b0; #3 rst = 1'b1;
        step();
        do_start();
        chk("zero_bout", 32'(bout), 1);
        chk("zero_busy", 32'(busy), 1);
        step();
        chk("zero_done", 32'(done), 1);
        step();

        // Full-range one-shot: 65536 enabled cycles to bout
        do_load(16'hFFFF);
        do_start();
        n = 1;
        while (!bout && n < 70000) begin
            step();
            n++;
        end
        chk("ffff_cycles", 32'(n), 65536);
        chk("ffff_dout0", 32'(dout), 0);
        step();
        chk("ffff_done", 32'(done), 1);
        step();

        // Async reset mid-count
        do_load(16'h1236);
        do_start();
        step(); step();
        chk("ar_at1234", 32'(dout), 32'h1234);
        #2 rst = 1'b0;
        #1;
        chk("async_dout", 32'(dout), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_done", 32'(done), 0);
        step();
        rst = 1'b1;
        step();
        chk("async_nodone", 32'(done), 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            load    = ($urandom_range(0, 99) < 5);
            start   = ($urandom_range(0, 99) < 30);
            stop    = ($urandom_range(0, 99) < 6);
            en      = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 99) < 4) auto_rl = ~auto_rl;
            din     = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 12));
            if ($urandom_range(0, 999) < 3) begin
                #2 rst = 1'b0; #2 rst = 1'b1;
            end
            step();
        end
        load = 1'b0; start = 1'b0; stop = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
